aha_ahb_mem_init_master: RTL
============================

# aha_ahb_mem_init_master

AHB-Lite initiator that fills a word-aligned memory region with an address-derived pattern and optionally reads it back and compares, reporting mismatches. It sits on a master port of the SoC AHB matrix next to the SRAM subsystem and provides post-reset memory initialisation and a simple memory self-test. It drives the same bus protocol the SRAM wrappers respond to, from the initiator side.

## Interface
- ADDR_W, 32: AHB address width.
- CNT_W, 16: width of word-count and error-count fields.
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- check_en  in  1  sampled with start; 1 = fill then read-back check, 0 = fill only.
- base_addr  in  ADDR_W  start byte address; bits [1:0] ignored (treated as 0).
- num_words  in  CNT_W  number of 32-bit words; sampled with start.
- seed  in  32  pattern seed; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion or abort.
- mismatch  out  1  sticky until next accepted start; any read-back compare failed.
- bus_err  out  1  sticky until next accepted start; run aborted by HRESP error.
- err_count  out  CNT_W  compare failures, saturating at all-ones.
- err_addr  out  ADDR_W  address of first compare failure or of the errored transfer.
- HADDR  out  ADDR_W;  HTRANS  out  2;  HWRITE  out  1;  HSIZE  out  3 (fixed 3'b010);  HBURST  out  3 (fixed SINGLE);  HPROT  out  4 (fixed 4'b0011);  HWDATA  out  32.
- HREADY  in  1;  HRESP  in  1;  HRDATA  in  32.

## Operation
- Pattern for word at byte address A: A ^ seed.
- States: IDLE, FILL, CHECK, DRAIN, DONE.
- IDLE: HTRANS=IDLE. Accepted start with num_words=0 -> DONE, no bus transfers. Otherwise latch inputs, clear mismatch/bus_err/err_count/err_addr, -> FILL.
- FILL: issue num_words NONSEQ writes, HADDR = base + 4*i, i = 0..num_words-1, address incrementing modulo 2^ADDR_W. Every transfer NONSEQ SINGLE, back-to-back with no IDLE cycles. HWDATA for transfer i is driven in its data phase (the cycle after its address phase is accepted) and held until HREADY=1.
- After the last write address is accepted: -> CHECK if check_en, else -> DRAIN.
- CHECK: issue num_words NONSEQ reads over the same addresses. The first read address phase overlaps the last write data phase. On each read data phase completing (HREADY=1, HRESP=0), compare HRDATA with the expected pattern; on mismatch set mismatch, increment err_count (saturating), record err_addr if first failure. After the last read address is accepted -> DRAIN.
- DRAIN: HTRANS=IDLE; wait for the outstanding data phase to complete, then -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Address phase advances only when HREADY=1; while HREADY=0 all address-phase outputs and HWDATA are held stable.
- HRESP=1 observed with HREADY=0 (first error cycle): in the next cycle drive HTRANS=IDLE (cancel any pending address), set bus_err, err_addr = address of the errored transfer, wait for HREADY=1, then -> DONE. No further transfers are issued.
- A start arriving while busy is ignored.

## Timing
- All outputs are registered. Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, mismatch=0, bus_err=0, err_count=0, err_addr=0. HSIZE, HBURST and HPROT are constants.
- Synchronous reset mid-run: at the reset edge all state returns to IDLE and HTRANS=IDLE is driven in the following cycle. The in-flight transfer is abandoned.
- Start sampled at edge 0; first NONSEQ is visible in cycle 1.
- Zero wait states, N words:
  - Fill only: write address phases in cycles 1..N; last data phase in cycle N+1; done in cycle N+2.
  - Fill and check: read address phases in cycles N+1..2N; last read data phase in cycle 2N+1; done in cycle 2N+2.
- Each wait state (HREADY=0) delays every later event by one cycle.
- num_words=0: done in cycle 1, busy is never asserted.

## Test plan
- Fill-only, base=0x2000_0000, N=4, seed=0, zero wait: writes to 0x..00/04/08/0C with HWDATA equal to the address; done in cycle 6; mismatch=0.
- Fill+check, N=8, seed=0xA5A5_A5A5, responder model returns correct data with random HREADY stalls: reads match, err_count=0, and HADDR/HWDATA stay stable during every stall.
- Fill+check, N=4, responder corrupts the read of base+8: mismatch=1, err_count=1, err_addr=base+8.
- Responder returns a 2-cycle ERROR on write index 2 of N=6: HTRANS=IDLE in the second error cycle, bus_err=1, err_addr=base+8, exactly 3 address phases issued, then done.
- Wrap and corner cases: base=0xFFFF_FFF8, N=4 gives addresses FFF8, FFFC, 0000, 0004; N=0 gives an immediate done with no transfers; HRESET asserted mid-FILL gives HTRANS=IDLE and all outputs at reset values the next cycle; start while busy is ignored.

Source files
------------

// File: rtl/aha_ahb_mem_init_master.sv
// AHB-Lite initiator that fills a word-aligned region with (address ^ seed)
// and optionally reads it back, counting and locating compare failures.
module aha_ahb_mem_init_master #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              check_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic              bus_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [31:0]       HRDATA
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         seed_q, seed_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                chk_q, chk_d;
  // transfer currently in its data phase
  logic                dp_vld_q, dp_vld_d;
  logic                dp_wr_q, dp_wr_d;
  logic [ADDR_W-1:0]   dp_addr_q, dp_addr_d;

  logic                busy_d, done_d, mismatch_d, bus_err_d, hwrite_d;
  logic [CNT_W-1:0]    err_count_d;
  logic [ADDR_W-1:0]   err_addr_d, haddr_d;
  logic [1:0]          htrans_d;
  logic [31:0]         hwdata_d;
  logic                acc;
  logic [ADDR_W-1:0]   base_al;

  function automatic logic [31:0] pattern(input logic [ADDR_W-1:0] a, input logic [31:0] s);
    return 32'(a) ^ s;
  endfunction

  assign HSIZE   = 3'b010;
  assign HBURST  = 3'b000;
  assign HPROT   = 4'b0011;
  assign base_al = base_addr & ~ADDR_W'(3);
  assign acc     = HREADY && (HTRANS == TR_NONSEQ);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    seed_d      = seed_q;
    n_d         = n_q;
    rem_d       = rem_q;
    chk_d       = chk_q;
    dp_vld_d    = dp_vld_q;
    dp_wr_d     = dp_wr_q;
    dp_addr_d   = dp_addr_q;
    busy_d      = busy;
    done_d      = 1'b0;
    mismatch_d  = mismatch;
    bus_err_d   = bus_err;
    err_count_d = err_count;
    err_addr_d  = err_addr;
    haddr_d     = HADDR;
    htrans_d    = HTRANS;
    hwrite_d    = HWRITE;
    hwdata_d    = HWDATA;

    // data phase completes on HREADY; reads are compared only on OKAY
    if (HREADY && dp_vld_q) begin
      dp_vld_d = 1'b0;
      if (!dp_wr_q && !HRESP && (HRDATA != pattern(dp_addr_q, seed_q))) begin
        mismatch_d = 1'b1;
        if (err_count != '1) err_count_d = err_count + CNT_W'(1);
        if (!mismatch) err_addr_d = dp_addr_q;
      end
    end

    if (acc) begin
      dp_vld_d  = 1'b1;
      dp_wr_d   = HWRITE;
      dp_addr_d = HADDR;
      rem_d     = rem_q - CNT_W'(1);
      if (HWRITE) hwdata_d = pattern(HADDR, seed_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            base_d      = base_al;
            seed_d      = seed;
            n_d         = num_words;
            rem_d       = num_words;
            chk_d       = check_en;
            mismatch_d  = 1'b0;
            bus_err_d   = 1'b0;
            err_count_d = '0;
            err_addr_d  = '0;
            haddr_d     = base_al;
            htrans_d    = TR_NONSEQ;
            hwrite_d    = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (acc) begin
          if (rem_q == CNT_W'(1)) begin
            if (chk_q) begin
              // read-back starts right behind the last write's data phase
              state_d  = S_CHECK;
              haddr_d  = base_q;
              hwrite_d = 1'b0;
              rem_d    = n_q;
            end else begin
              state_d  = S_DRAIN;
              htrans_d = TR_IDLE;
            end
          end else begin
            haddr_d = HADDR + ADDR_W'(4);
          end
        end
      end
      S_CHECK: begin
        if (acc) begin
          if (rem_q == CNT_W'(1)) begin
            state_d  = S_DRAIN;
            htrans_d = TR_IDLE;
          end else begin
            haddr_d = HADDR + ADDR_W'(4);
          end
        end
      end
      S_DRAIN: begin
        if (HREADY) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // first ERROR cycle: withdraw any pending address, then drain the response
    if (dp_vld_q && HRESP && !HREADY && !bus_err &&
        (state_q == S_FILL || state_q == S_CHECK || state_q == S_DRAIN)) begin
      bus_err_d  = 1'b1;
      err_addr_d = dp_addr_q;
      htrans_d   = TR_IDLE;
      state_d    = S_DRAIN;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      seed_q    <= '0;
      n_q       <= '0;
      rem_q     <= '0;
      chk_q     <= 1'b0;
      dp_vld_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      bus_err   <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      n_q       <= n_d;
      rem_q     <= rem_d;
      chk_q     <= chk_d;
      dp_vld_q  <= dp_vld_d;
      dp_wr_q   <= dp_wr_d;
      dp_addr_q <= dp_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      mismatch  <= mismatch_d;
      bus_err   <= bus_err_d;
      err_count <= err_count_d;
      err_addr  <= err_addr_d;
      HADDR     <= haddr_d;
      HTRANS    <= htrans_d;
      HWRITE    <= hwrite_d;
      HWDATA    <= hwdata_d;
    end
  end

endmodule
